// File: rtl/pipe_stage_reg_if.sv
// Handshake bundle for pipe_stage_reg: upstream (in_*) and downstream (out_*) sides.
//   master : environment side, drives in_valid/in_data/out_ready
//   slave  : the stage, drives in_ready/out_valid/out_data
interface pipe_stage_reg_if #(
  parameter int unsigned WIDTH = 96
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline stage register with valid/ready handshake, synchronous
// flush and a saturating stall counter.
// Build option: PIPE_SKID_EN defined -> 2-entry skid build with registered
// in_ready; undefined -> single-entry build with combinational in_ready.
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-high reset
//   flush     synchronous clear of all held entries (bubble injection)
//   bus       pipe_stage_reg_if.slave (in_valid/in_ready/in_data,
//             out_valid/out_ready/out_data)
//   stall_cnt cycles with out_valid=1 and out_ready=0, saturating
module pipe_stage_reg #(
  parameter int unsigned      WIDTH  = 96,
  parameter logic [WIDTH-1:0] BUBBLE = {WIDTH{1'b0}},
  parameter int unsigned      CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  pipe_stage_reg_if.slave  bus,
  output logic [CNT_W-1:0] stall_cnt
);

  logic             accept;
  logic             xfer;
  logic             main_vld;
  logic [WIDTH-1:0] main_q;
  logic [CNT_W-1:0] stall_q;

  assign accept = bus.in_valid && bus.in_ready;
  assign xfer   = main_vld && bus.out_ready;

  // Output mux keeps out_data at BUBBLE whenever no live payload is held.
  assign bus.out_valid = main_vld;
  assign bus.out_data  = main_vld ? main_q : BUBBLE;

`ifdef PIPE_SKID_EN

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  state_e           state_q;
  state_e           state_d;
  logic             in_ready_q;
  logic [WIDTH-1:0] skid_q;
  logic             main_ld;
  logic             main_from_skid;
  logic             skid_ld;

  // State register; in_ready is precomputed from the next state so it is a flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != ST_TWO);
    end
  end

  // Next-state and data-load decode.
  always_comb begin
    state_d        = state_q;
    main_ld        = 1'b0;
    main_from_skid = 1'b0;
    skid_ld        = 1'b0;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d = ST_ONE;
            main_ld = 1'b1;
          end
        end
        ST_ONE: begin
          if (accept && !xfer) begin
            state_d = ST_TWO;
            skid_ld = 1'b1;
          end else if (!accept && xfer) begin
            state_d = ST_EMPTY;
          end else if (accept && xfer) begin
            main_ld = 1'b1;
          end
        end
        ST_TWO: begin
          if (xfer) begin
            state_d        = ST_ONE;
            main_from_skid = 1'b1;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // Payload registers carry no reset; validity lives in the state.
  always_ff @(posedge clk) begin
    if (main_ld) begin
      main_q <= bus.in_data;
    end else if (main_from_skid) begin
      main_q <= skid_q;
    end
    if (skid_ld) begin
      skid_q <= bus.in_data;
    end
  end

  assign bus.in_ready = in_ready_q;
  assign main_vld     = (state_q != ST_EMPTY);

`else

  logic vld_q;
  logic vld_d;
  logic main_ld;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= 1'b0;
    end else begin
      vld_q <= vld_d;
    end
  end

  // Valid-bit update; flush wins and drops any same-cycle accept.
  always_comb begin
    vld_d   = vld_q;
    main_ld = 1'b0;
    if (flush) begin
      vld_d = 1'b0;
    end else if (accept) begin
      vld_d   = 1'b1;
      main_ld = 1'b1;
    end else if (xfer) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (main_ld) begin
      main_q <= bus.in_data;
    end
  end

  // Accept when empty or when the held payload leaves this same cycle.
  assign bus.in_ready = !vld_q || bus.out_ready;
  assign main_vld     = vld_q;

`endif

  // Saturating stall counter; only rst clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else if (main_vld && !bus.out_ready && (stall_q != {CNT_W{1'b1}})) begin
      stall_q <= stall_q + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_q;

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised elastic pipeline stage register replacing the fixed IF/ID latch pattern between any two core stages (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries a WIDTH-bit payload with a valid/ready handshake, a synchronous flush that injects a bubble, and a saturating stall counter for performance monitoring. An optional skid entry makes in_ready a registered signal without losing throughput.

## Interface
- WIDTH, 96, payload width in bits (IF/ID use: instr, PC, PC+4 concatenated).
- BUBBLE, {WIDTH{1'b0}}, value driven on out_data whenever out_valid=0. IF/ID instances set the instruction field to 32'h00000013 (NOP).
- CNT_W, 16, stall counter width.
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  synchronous clear of all held entries.
- in_valid  in  1  upstream has a payload.
- in_ready  out  1  stage can accept a payload this cycle.
- in_data  in  WIDTH  upstream payload.
- out_valid  out  1  out_data holds a live payload.
- out_ready  in  1  downstream accepts out_data this cycle.
- out_data  out  WIDTH  held payload, or BUBBLE when not valid.
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0.

## Operation
- Accept: in_valid && in_ready at a rising edge. Transfer out: out_valid && out_ready at a rising edge.
- Skid build (PIPE_SKID_EN defined): states EMPTY, ONE (main entry valid), TWO (main and skid entries valid).
  - EMPTY: accept -> ONE, main <= in_data.
  - ONE: accept with no transfer -> TWO, skid <= in_data. Transfer with no accept -> EMPTY. Both -> ONE, main <= in_data.
  - TWO: transfer -> ONE, main <= skid. in_valid is ignored because in_ready=0.
  - in_ready = (state != TWO), driven from a register.
- Single-entry build (macro absent): a single valid bit and a main register.
  - in_ready = !out_valid || out_ready, combinational.
  - accept loads main. A transfer with no accept clears valid.
- out_valid = main entry valid. out_data = main when valid, else BUBBLE.
- Flush has the highest priority after rst. On the next edge all entries are invalidated and the state becomes EMPTY. Any same-cycle accept is dropped and any same-cycle transfer still counts downstream. A flush held high keeps the stage empty, and in_ready stays asserted during flush.
- Data registers do not need a reset; valid bits and state do. out_data must still equal BUBBLE after reset because of the output mux.
- stall_cnt increments by 1 on each edge where out_valid && !out_ready. It saturates at 2^CNT_W-1 with no wrap. Only rst clears it; flush does not.

## Timing
- Reset values: out_valid=0, out_data=BUBBLE, in_ready=1, stall_cnt=0, state EMPTY.
- Latency: a payload accepted at edge N is visible on out_data/out_valid after edge N and can transfer at edge N+1.
- Throughput: 1 payload/cycle when out_ready is held high, in both builds.
- Skid build: after out_ready drops, one more payload is accepted into skid, then in_ready deasserts on the following cycle. No payload is lost or duplicated.
- Order is strictly FIFO. Payloads are never reordered.
- rst asserted mid-operation clears state asynchronously within the cycle. Payloads in flight are discarded.

## Configuration
- PIPE_SKID_EN defined: 2-entry skid build, registered in_ready, no combinational in_ready->out_ready path.
- PIPE_SKID_EN undefined: single-entry build, combinational in_ready, area roughly halved.
- Port list and external handshake semantics are identical in both builds.

## Test plan
- Reset: assert rst mid-stream with WIDTH=96 and BUBBLE NOP -> immediately out_valid=0, out_data=BUBBLE, in_ready=1, stall_cnt=0.
- Streaming: out_ready=1, in_valid=1, send data 1..8 on consecutive cycles -> out_data shows 1..8 on consecutive cycles, one cycle after each accept.
- Backpressure (skid): hold out_ready=0 for 4 cycles while in_valid=1 with data A,B,C -> A held, B in skid, in_ready=0, C stalled, stall_cnt=4. Release -> A,B,C in order with no gap.
- Flush: stage in TWO with flush=1 and in_valid=1 data D on the same edge -> next cycle out_valid=0, out_data=BUBBLE, D not delivered, stall_cnt unchanged.
- Saturation: CNT_W=4, out_valid=1, out_ready=0 for 20 cycles -> stall_cnt stops at 15.
- Repeat the streaming and backpressure scenarios with PIPE_SKID_EN undefined -> same order and values, and in_ready follows out_ready in the same cycle.
